// File: rtl/pll_freq_ctrl.sv
// pll_freq_ctrl: runtime M/N/C divide controller for the hashing-core PLL.
// Latches a divide request, range-checks it, encodes it into the PLL scan-chain
// image, shifts the image out serially, pulses configupdate and then waits for
// scandone and a fresh lock, finishing with a done pulse or a coded err pulse.

module pll_freq_ctrl #(
  parameter int CNT_W        = 8,
  parameter int NUM_C        = 1,
  parameter int SCAN_DIV     = 2,
  parameter int DONE_TIMEOUT = 1023,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [CNT_W:0]                 req_m,
  input  logic [CNT_W:0]                 req_n,
  input  logic [NUM_C*(CNT_W+1)-1:0]     req_c,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     err_code,
  output logic                           pll_scanclk,
  output logic                           pll_scanclkena,
  output logic                           pll_scandata,
  output logic                           pll_configupdate,
  input  logic                           pll_scandone,
  input  logic                           pll_locked
);

  // Geometry of one counter field and of the whole chain.
  localparam int DIV_W     = CNT_W + 1;
  localparam int FLD_W     = 2 * CNT_W + 2;
  localparam int NUM_F     = NUM_C + 2;
  localparam int CHAIN_LEN = NUM_F * FLD_W;
  localparam int BIT_W     = $clog2(CHAIN_LEN);
  localparam int DIV_CW    = $clog2(SCAN_DIV + 1);
  localparam int DTO_W     = $clog2(DONE_TIMEOUT + 1);
  localparam int LTO_W     = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_CW-1:0] HALF_LAST = DIV_CW'(SCAN_DIV - 1);
  localparam logic [DTO_W-1:0]  DONE_LAST = DTO_W'(DONE_TIMEOUT - 1);
  localparam logic [LTO_W-1:0]  LOCK_LAST = LTO_W'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_DONE  = 2'd2;
  localparam logic [1:0] ERR_LOCK  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_UPDATE,
    S_WAIT_DONE,
    S_WAIT_LOCK
  } state_t;

  // A divide value is legal when it is non-zero and not the all-ones code,
  // which is the only value above 2^(CNT_W+1)-2 representable in DIV_W bits.
  function automatic logic div_in_range(input logic [DIV_W-1:0] d);
    return (d != '0) && (d != '1);
  endfunction

  // Field layout, MSB first: {bypass, high[CNT_W], odd, low[CNT_W]}.
  // high rounds up and low rounds down so that high+low == d for odd d.
  function automatic logic [FLD_W-1:0] encode_div(input logic [DIV_W-1:0] d);
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    high = CNT_W'(({1'b0, d} + {{DIV_W{1'b0}}, 1'b1}) >> 1);
    low  = d[DIV_W-1:1];
    if (d == DIV_W'(1)) begin
      return {1'b1, {(FLD_W-1){1'b0}}};
    end
    return {1'b0, high, d[0], low};
  endfunction

  state_t                       state_q, state_d;
  logic [DIV_W-1:0]             req_m_q, req_m_d;
  logic [DIV_W-1:0]             req_n_q, req_n_d;
  logic [NUM_C*DIV_W-1:0]       req_c_q, req_c_d;
  logic [CHAIN_LEN-1:0]         shreg_q, shreg_d;
  logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DIV_CW-1:0]            div_cnt_q, div_cnt_d;
  logic                         scanclk_q, scanclk_d;
  logic                         scanclkena_q, scanclkena_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic [1:0]                   err_code_q, err_code_d;
  logic [DTO_W-1:0]             done_tmr_q, done_tmr_d;
  logic [LTO_W-1:0]             lock_tmr_q, lock_tmr_d;
  logic                         seen_low_q, seen_low_d;
  logic                         scandone_meta_q, scandone_meta_d;
  logic                         scandone_sync_q, scandone_sync_d;
  logic                         scandone_prev_q, scandone_prev_d;
  logic                         locked_meta_q, locked_meta_d;
  logic                         locked_sync_q, locked_sync_d;

  logic [CHAIN_LEN-1:0]         chain_image;
  logic [NUM_F-1:0]             field_ok;
  logic                         all_ok;
  logic                         scandone_rise;

  // Output counters occupy the low fields, C0 in the LSBs.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_C; gi++) begin : g_cfield
      assign chain_image[gi*FLD_W +: FLD_W] = encode_div(req_c_q[gi*DIV_W +: DIV_W]);
      assign field_ok[gi]                   = div_in_range(req_c_q[gi*DIV_W +: DIV_W]);
    end
  endgenerate

  assign chain_image[NUM_C*FLD_W +: FLD_W]     = encode_div(req_n_q);
  assign chain_image[(NUM_C+1)*FLD_W +: FLD_W] = encode_div(req_m_q);
  assign field_ok[NUM_C]                       = div_in_range(req_n_q);
  assign field_ok[NUM_C+1]                     = div_in_range(req_m_q);
  assign all_ok                                = &field_ok;

  assign scandone_rise = scandone_sync_q & ~scandone_prev_q;

  assign req_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign err              = err_q;
  assign err_code         = err_code_q;
  assign pll_scanclk      = scanclk_q;
  assign pll_scanclkena   = scanclkena_q;
  assign pll_scandata     = shreg_q[CHAIN_LEN-1];
  assign pll_configupdate = (state_q == S_UPDATE);

  // Next-state, shift sequencing, timeouts and input synchronisers.
  always_comb begin
    state_d         = state_q;
    req_m_d         = req_m_q;
    req_n_d         = req_n_q;
    req_c_d         = req_c_q;
    shreg_d         = shreg_q;
    bit_cnt_d       = bit_cnt_q;
    div_cnt_d       = div_cnt_q;
    scanclk_d       = scanclk_q;
    scanclkena_d    = scanclkena_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    err_code_d      = err_code_q;
    done_tmr_d      = done_tmr_q;
    lock_tmr_d      = lock_tmr_q;
    seen_low_d      = seen_low_q;
    scandone_meta_d = pll_scandone;
    scandone_sync_d = scandone_meta_q;
    scandone_prev_d = scandone_sync_q;
    locked_meta_d   = pll_locked;
    locked_sync_d   = locked_meta_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_m_d = req_m;
          req_n_d = req_n;
          req_c_d = req_c;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!all_ok) begin
          err_d      = 1'b1;
          err_code_d = ERR_RANGE;
          state_d    = S_IDLE;
        end else begin
          shreg_d      = chain_image;
          bit_cnt_d    = '0;
          div_cnt_d    = '0;
          scanclk_d    = 1'b0;
          scanclkena_d = 1'b1;
          state_d      = S_SHIFT;
        end
      end

      // Data only moves on the falling scanclk transition, so it is stable
      // for the whole high phase and across every rising edge.
      S_SHIFT: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d = '0;
          if (!scanclk_q) begin
            scanclk_d = 1'b1;
          end else begin
            scanclk_d = 1'b0;
            shreg_d   = {shreg_q[CHAIN_LEN-2:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              scanclkena_d = 1'b0;
              state_d      = S_UPDATE;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_CW'(1);
        end
      end

      S_UPDATE: begin
        done_tmr_d = '0;
        state_d    = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (scandone_rise) begin
          lock_tmr_d = '0;
          seen_low_d = 1'b0;
          state_d    = S_WAIT_LOCK;
        end else if (done_tmr_q == DONE_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_DONE;
          state_d    = S_IDLE;
        end else if (done_tmr_q != '1) begin
          done_tmr_d = done_tmr_q + DTO_W'(1);
        end
      end

      // A lock only counts once locked has been observed low after the
      // update; a lock that never dropped is a stale one and times out.
      S_WAIT_LOCK: begin
        if (seen_low_q && locked_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (lock_tmr_q == LOCK_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_LOCK;
          state_d    = S_IDLE;
        end else begin
          if (lock_tmr_q != '1) begin
            lock_tmr_d = lock_tmr_q + LTO_W'(1);
          end
          if (!locked_sync_q) begin
            seen_low_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any shift in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      req_m_q         <= '0;
      req_n_q         <= '0;
      req_c_q         <= '0;
      shreg_q         <= '0;
      bit_cnt_q       <= '0;
      div_cnt_q       <= '0;
      scanclk_q       <= 1'b0;
      scanclkena_q    <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      err_code_q      <= 2'd0;
      done_tmr_q      <= '0;
      lock_tmr_q      <= '0;
      seen_low_q      <= 1'b0;
      scandone_meta_q <= 1'b0;
      scandone_sync_q <= 1'b0;
      scandone_prev_q <= 1'b0;
      locked_meta_q   <= 1'b0;
      locked_sync_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_m_q         <= req_m_d;
      req_n_q         <= req_n_d;
      req_c_q         <= req_c_d;
      shreg_q         <= shreg_d;
      bit_cnt_q       <= bit_cnt_d;
      div_cnt_q       <= div_cnt_d;
      scanclk_q       <= scanclk_d;
      scanclkena_q    <= scanclkena_d;
      done_q          <= done_d;
      err_q           <= err_d;
      err_code_q      <= err_code_d;
      done_tmr_q      <= done_tmr_d;
      lock_tmr_q      <= lock_tmr_d;
      seen_low_q      <= seen_low_d;
      scandone_meta_q <= scandone_meta_d;
      scandone_sync_q <= scandone_sync_d;
      scandone_prev_q <= scandone_prev_d;
      locked_meta_q   <= locked_meta_d;
      locked_sync_q   <= locked_sync_d;
    end
  end

endmodule

// File: tb/tb_pll_freq_ctrl.sv
// Bench for pll_freq_ctrl: directed and randomized requests against a small
// arithmetic model of the chain image, plus a behavioural PLL that answers
// configupdate with scandone and a lock drop/relock.

module tb_pll_freq_ctrl;

  localparam int CNT_W     = 8;
  localparam int NUM_C     = 1;
  localparam int SCAN_DIV  = 2;
  localparam int DONE_TO   = 1023;
  localparam int LOCK_TO   = 3000;
  localparam int CHAIN_LEN = 54;
  localparam int SHIFT_CYC = CHAIN_LEN * 2 * SCAN_DIV;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] req_m;
  logic [8:0] req_n;
  logic [8:0] req_c;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       pll_scanclk;
  logic       pll_scanclkena;
  logic       pll_scandata;
  logic       pll_configupdate;
  logic       pll_scandone;
  logic       pll_locked;

  pll_freq_ctrl #(
    .CNT_W(CNT_W), .NUM_C(NUM_C), .SCAN_DIV(SCAN_DIV),
    .DONE_TIMEOUT(DONE_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_n(req_n), .req_c(req_c), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .pll_scanclk(pll_scanclk),
    .pll_scanclkena(pll_scanclkena), .pll_scandata(pll_scandata),
    .pll_configupdate(pll_configupdate), .pll_scandone(pll_scandone),
    .pll_locked(pll_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Monitor state, written only by the monitor process.
  int        cyc, rise_cnt, ena_cnt, cfg_cnt, done_cnt, err_cnt, viol_cnt;
  bit        prev_sclk;
  bit        prev_sdata;
  bit [53:0] cap_vec;

  // PLL model controls (written by the main sequence) and its timestamp.
  bit ret_done;
  bit drop_lock;
  int sd_cyc;

  // Per-request results, written by the main sequence.
  int b_rise, b_ena, b_cfg, b_done, b_err, b_viol;
  int t_acc, cu_cyc, end_cyc;
  bit got_done, got_err, end_busy, end_ready;
  logic [1:0] got_code;

  // Samples the scan interface and counts pulses on every falling clk edge.
  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_sclk  <= pll_scanclk;
    prev_sdata <= pll_scandata;
    if (pll_scanclk && !prev_sclk) begin
      rise_cnt <= rise_cnt + 1;
      cap_vec  <= {cap_vec[52:0], pll_scandata};
    end
    if (pll_scanclk && (pll_scandata != prev_sdata)) viol_cnt <= viol_cnt + 1;
    if (pll_scanclkena)   ena_cnt  <= ena_cnt + 1;
    if (pll_configupdate) cfg_cnt  <= cfg_cnt + 1;
    if (done)             done_cnt <= done_cnt + 1;
    if (err)              err_cnt  <= err_cnt + 1;
  end

  // Behavioural PLL: scandone 20 cycles after configupdate, then optionally
  // drops locked for 100 cycles before relocking.
  initial begin
    pll_scandone = 1'b0;
    pll_locked   = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (pll_configupdate && ret_done) begin
        repeat (20) @(negedge clk);
        #1;
        pll_scandone = 1'b1;
        sd_cyc       = cyc;
        repeat (5) @(negedge clk);
        #1;
        pll_scandone = 1'b0;
        if (drop_lock) begin
          pll_locked = 1'b0;
          repeat (100) @(negedge clk);
          #1;
          pll_locked = 1'b1;
        end
      end
    end
  end

  // Reference field: {bypass, high, odd, low} from plain arithmetic.
  function automatic logic [17:0] fld(input int d);
    int high, odd, low;
    if (d == 1) return 18'h20000;
    high = (d + 1) / 2;
    odd  = d % 2;
    low  = d / 2;
    return 18'((high << 9) + (odd << 8) + low);
  endfunction

  function automatic logic [53:0] exp_chain(input int m, input int n, input int c);
    return {fld(m), fld(n), fld(c)};
  endfunction

  function automatic bit in_range(input int d);
    return (d >= 1) && (d <= 510);
  endfunction

  function automatic int pick_div();
    int r;
    r = int'($urandom_range(0, 11));
    case (r)
      0:       return 0;
      1:       return 511;
      2:       return 1;
      3:       return 510;
      default: return int'($urandom_range(2, 509));
    endcase
  endfunction

  function automatic logic [9:0] out_vec();
    return {req_ready, busy, done, err, err_code, pll_scanclk,
            pll_scanclkena, pll_scandata, pll_configupdate};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done or err. With hold set,
  // req_valid stays high and the request fields are scrambled while busy.
  task automatic do_req(input int m, input int n, input int c, input int budget, input bit hold);
    b_rise = rise_cnt; b_ena = ena_cnt; b_cfg = cfg_cnt;
    b_done = done_cnt; b_err = err_cnt; b_viol = viol_cnt;
    cu_cyc = -1; end_cyc = -1; got_done = 0; got_err = 0; got_code = 2'd0;
    end_busy = 1; end_ready = 0;
    @(negedge clk); #1;
    req_valid = 1'b1;
    req_m = 9'(m); req_n = 9'(n); req_c = 9'(c);
    t_acc = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (pll_configupdate && cu_cyc < 0) cu_cyc = cyc;
      if (done || err) begin
        got_done  = done;
        got_err   = err;
        got_code  = err_code;
        end_cyc   = cyc;
        end_busy  = busy;
        end_ready = req_ready;
        break;
      end
      if (hold) begin
        req_m = 9'($urandom); req_n = 9'($urandom); req_c = 9'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("outcome_seen", 64'(end_cyc >= 0), 64'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_success(input string tag, input int m, input int n, input int c);
    $display("txn %s: M=%0d N=%0d C0=%0d done=%0d err=%0d chain=0x%0h",
             tag, m, n, c, got_done, got_err, cap_vec);
    chk({tag, "_done"},       64'(got_done), 64'd1);
    chk({tag, "_no_err"},     64'(got_err), 64'd0);
    chk({tag, "_bits"},       64'(cap_vec), 64'(exp_chain(m, n, c)));
    chk({tag, "_rises"},      64'(rise_cnt - b_rise), 64'(CHAIN_LEN));
    chk({tag, "_ena_cycles"}, 64'(ena_cnt - b_ena), 64'(SHIFT_CYC));
    chk({tag, "_cfg_pulses"}, 64'(cfg_cnt - b_cfg), 64'd1);
    chk({tag, "_done_pulses"},64'(done_cnt - b_done), 64'd1);
    chk({tag, "_err_pulses"}, 64'(err_cnt - b_err), 64'd0);
    chk({tag, "_busy_at_done"},  64'(end_busy), 64'd0);
    chk({tag, "_ready_at_done"}, 64'(end_ready), 64'd1);
    chk({tag, "_data_stable"},   64'(viol_cnt - b_viol), 64'd0);
  endtask

  task automatic check_range_err(input string tag, input int m, input int n, input int c);
    $display("txn %s: M=%0d N=%0d C0=%0d err=%0d code=%0d", tag, m, n, c, got_err, got_code);
    chk({tag, "_err"},        64'(got_err), 64'd1);
    chk({tag, "_code"},       64'(got_code), 64'd1);
    chk({tag, "_latency"},    64'(end_cyc - t_acc), 64'd2);
    chk({tag, "_no_shift"},   64'(ena_cnt - b_ena), 64'd0);
    chk({tag, "_no_cfg"},     64'(cfg_cnt - b_cfg), 64'd0);
    chk({tag, "_no_done"},    64'(done_cnt - b_done), 64'd0);
  endtask

  initial begin
    int m, n, c, d;
    bit reached;
    checks = 0; errors = 0;
    ret_done = 1; drop_lock = 1;
    reset = 1'b1; req_valid = 1'b0; req_m = '0; req_n = '0; req_c = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'(out_vec()), 64'h200);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("after_release_outputs", 64'(out_vec()), 64'h200);

    // Reference transaction from the plan.
    do_req(10, 1, 20, 6000, 0);
    check_success("basic", 10, 1, 20);
    chk("basic_literal_chain", 64'(cap_vec),
        64'({1'b0, 8'h05, 1'b0, 8'h05, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h0A, 1'b0, 8'h0A}));

    // Odd divide and the largest legal divide.
    do_req(7, 510, 3, 6000, 0);
    check_success("odd_max", 7, 510, 3);
    chk("m7_field",   64'(cap_vec[53:36]), 64'h00903);
    chk("n510_field", 64'(cap_vec[35:18]), 64'h1FEFF);

    // Range errors.
    do_req(511, 2, 2, 100, 0);
    check_range_err("m511", 511, 2, 2);
    do_req(4, 4, 0, 100, 0);
    check_range_err("c0_zero", 4, 4, 0);
    do_req(4, 0, 4, 100, 0);
    check_range_err("n_zero", 4, 0, 4);

    // scandone never returns.
    ret_done = 0;
    do_req(20, 2, 4, 6000, 0);
    $display("txn done_timeout: err=%0d code=%0d wait=%0d", got_err, got_code, end_cyc - cu_cyc);
    chk("dto_err",      64'(got_err), 64'd1);
    chk("dto_code",     64'(got_code), 64'd2);
    chk("dto_latency",  64'(end_cyc - cu_cyc), 64'(DONE_TO + 1));
    chk("dto_ready",    64'(end_ready), 64'd1);
    chk("dto_no_done",  64'(done_cnt - b_done), 64'd0);
    chk("dto_cfg",      64'(cfg_cnt - b_cfg), 64'd1);
    ret_done = 1;

    // locked stays high: stale lock must time out.
    drop_lock = 0;
    do_req(30, 3, 6, 6000, 0);
    d = end_cyc - sd_cyc;
    $display("txn lock_timeout: err=%0d code=%0d wait=%0d", got_err, got_code, d);
    chk("lto_err",     64'(got_err), 64'd1);
    chk("lto_code",    64'(got_code), 64'd3);
    chk("lto_window",  64'((d >= LOCK_TO + 2) && (d <= LOCK_TO + 4)), 64'd1);
    chk("lto_no_done", 64'(done_cnt - b_done), 64'd0);
    drop_lock = 1;

    // err_code survives a later successful request.
    do_req(12, 2, 8, 6000, 0);
    check_success("after_lto", 12, 2, 8);
    chk("err_code_hold", 64'(err_code), 64'd3);

    // Reset in the middle of the shift at bit 20.
    b_rise = rise_cnt; b_cfg = cfg_cnt;
    @(negedge clk); #1;
    req_valid = 1'b1; req_m = 9'd100; req_n = 9'd3; req_c = 9'd9;
    @(negedge clk); #1;
    req_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 1000; i++) begin
      if (rise_cnt - b_rise >= 20) begin
        reached = 1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("rst_reach_bit20", 64'(reached), 64'd1);
    chk("rst_was_shifting", 64'(pll_scanclkena), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    $display("txn reset_mid_shift: outputs=0x%0h", out_vec());
    chk("rst_mid_shift_outputs", 64'(out_vec()), 64'h200);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_no_configupdate", 64'(cfg_cnt - b_cfg), 64'd0);
    chk("rst_idle_after", 64'(out_vec()), 64'h200);
    do_req(100, 3, 9, 6000, 0);
    check_success("post_reset", 100, 3, 9);

    // req_valid held high while busy with changing fields.
    do_req(45, 2, 300, 6000, 1);
    check_success("held_valid", 45, 2, 300);

    // Randomized requests.
    for (int k = 0; k < 12; k++) begin
      m = pick_div(); n = pick_div(); c = pick_div();
      do_req(m, n, c, 6000, 0);
      if (in_range(m) && in_range(n) && in_range(c)) check_success("rand", m, n, c);
      else check_range_err("rand_bad", m, n, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
